arbitro_hash: RTL and testbench

- Shares one XOR-fold hash unit (512-bit cache line -> 8-bit hash) between NUM_REQ requesters, e.g. cache banks and the prefetcher.
- Round-robin arbitration, one line captured per operation, registered hash result returned with the requester ID over a valid/ready response channel.
- Sits between the cache line buffers and the set-index / tag-hash consumers.

---
 rtl/arbitro_hash.sv | 115 +++++++++++
 tb/tb_arbitro_hash.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_hash.sv
// Round-robin arbiter sharing one XOR-fold hash unit (512-bit line -> 8-bit hash) among NUM_REQ requesters.
// Optional build macro ARB_PRIORIDADE_FIXA_EN selects fixed lowest-index-wins priority instead of round-robin.
module arbitro_hash #(
  parameter int NUM_REQ    = 4,
  parameter int LARGURA_ID = ($clog2(NUM_REQ) > 0 ? $clog2(NUM_REQ) : 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valido,
  input  logic [512*NUM_REQ-1:0]   req_linha,
  output logic [NUM_REQ-1:0]       req_pronto,
  output logic                     resp_valido,
  output logic [7:0]               resp_hash,
  output logic [LARGURA_ID-1:0]    resp_id,
  input  logic                     resp_pronto,
  output logic [1:0]               estado_dbg
);

  // Handshake rule for both channels: a transfer happens on a rising edge where
  // valid and ready are both high; the producer holds payload stable until then.

  typedef enum logic [1:0] {
    LIVRE = 2'd0,
    HASH  = 2'd1,
    RESP  = 2'd2
  } estado_t;

  estado_t               estado, prox_estado;
  logic [511:0]          linha_reg;
  logic [LARGURA_ID-1:0] id_reg;
  logic [LARGURA_ID-1:0] vencedor;
  logic                  achou;
  logic [7:0]            hash_comb;
`ifndef ARB_PRIORIDADE_FIXA_EN
  logic [LARGURA_ID-1:0] ptr;
`endif

  assign estado_dbg = estado;

  // Winner search: rotating start at ptr, or fixed start at index 0.
  always_comb begin
    int idx;
    achou    = 1'b0;
    vencedor = '0;
    idx      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
`ifdef ARB_PRIORIDADE_FIXA_EN
      idx = off;
`else
      idx = (int'(ptr) + off) % NUM_REQ;
`endif
      if (!achou && req_valido[idx]) begin
        achou    = 1'b1;
        vencedor = LARGURA_ID'(idx);
      end
    end
  end

  always_comb begin
    req_pronto = '0;
    if (estado == LIVRE && achou) req_pronto[vencedor] = 1'b1;
  end

  always_comb begin
    hash_comb = '0;
    for (int k = 0; k < 64; k++) hash_comb = hash_comb ^ linha_reg[8*k +: 8];
  end

  always_comb begin
    prox_estado = estado;
    case (estado)
      LIVRE:   if (achou) prox_estado = HASH;
      HASH:    prox_estado = RESP;
      RESP:    if (resp_pronto) prox_estado = LIVRE;
      default: prox_estado = LIVRE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado      <= LIVRE;
      linha_reg   <= '0;
      id_reg      <= '0;
      resp_valido <= 1'b0;
      resp_hash   <= '0;
      resp_id     <= '0;
`ifndef ARB_PRIORIDADE_FIXA_EN
      ptr         <= '0;
`endif
    end else begin
      estado <= prox_estado;
      case (estado)
        LIVRE: begin
          if (achou) begin
            linha_reg <= req_linha[int'(vencedor)*512 +: 512];
            id_reg    <= vencedor;
`ifndef ARB_PRIORIDADE_FIXA_EN
            ptr       <= (int'(vencedor) == NUM_REQ - 1) ? '0 : vencedor + LARGURA_ID'(1);
`endif
          end
        end
        HASH: begin
          resp_hash   <= hash_comb;
          resp_id     <= id_reg;
          resp_valido <= 1'b1;
        end
        RESP: begin
          if (resp_pronto) resp_valido <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_hash.sv
// Directed, table-driven bench for arbitro_hash (NUM_REQ = 4): hash vectors plus
// hand-written arbitration, back-pressure, reset and withdrawal sequences.
module tb_arbitro_hash;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valido;
  logic [512*N-1:0] req_linha;
  logic [N-1:0]    req_pronto;
  logic            resp_valido;
  logic [7:0]      resp_hash;
  logic [1:0]      resp_id;
  logic            resp_pronto;
  logic [1:0]      estado_dbg;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]   id;
    logic [511:0] linha;
    logic [7:0]   hash;
  } vec_t;

  vec_t vt[7];

  arbitro_hash #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valido(req_valido), .req_linha(req_linha),
    .req_pronto(req_pronto), .resp_valido(resp_valido), .resp_hash(resp_hash),
    .resp_id(resp_id), .resp_pronto(resp_pronto), .estado_dbg(estado_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge and sample 1 ns later; grants must never be multi-hot.
  task automatic tick();
    @(posedge clk);
    #1;
    check("onehot0", 32'($onehot0(req_pronto)), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valido = '0;
    req_linha = '0;
    resp_pronto = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] rr_exp(input int g);
`ifdef ARB_PRIORIDADE_FIXA_EN
    return 8'd0;
`else
    return 8'(g % N);
`endif
  endfunction

  // driver: one isolated request, full transaction checked
  task automatic run_single(input vec_t v);
    req_linha = '0;
    req_linha[int'(v.id)*512 +: 512] = v.linha;
    req_valido = N'(1) << v.id;
    resp_pronto = 1'b1;
    #1;
    check("single_grant", 32'(req_pronto), 32'(N'(1) << v.id));
    tick();
    req_valido = '0;
    #1;
    check("single_hash_state_valid", 32'(resp_valido), 0);
    check("single_hash_state_pronto", 32'(req_pronto), 0);
    tick();
    check("single_resp_valid", 32'(resp_valido), 1);
    check("single_resp_hash", 32'(resp_hash), 32'(v.hash));
    check("single_resp_id", 32'(resp_id), 32'(v.id));
    tick();
    check("single_resp_done", 32'(resp_valido), 0);
  endtask

  initial begin
    logic [511:0] l;
    logic [7:0] h0;
    logic [1:0] id0;

    // scoreboard table: hand-computed hashes
    l = '0; l[7:0] = 8'hA5;                                    vt[0] = '{2'd0, l, 8'hA5};
    for (int k = 0; k < 64; k++) l[8*k +: 8] = 8'h01;          vt[1] = '{2'd1, l, 8'h00};
    for (int k = 0; k < 64; k++) l[8*k +: 8] = 8'(k);          vt[2] = '{2'd2, l, 8'h00};
    l = '0; l[511:504] = 8'hFF;                                vt[3] = '{2'd3, l, 8'hFF};
    l = '0; l[7:0] = 8'h12; l[47:40] = 8'h34;                  vt[4] = '{2'd1, l, 8'h26};
    for (int k = 0; k < 64; k++) l[8*k +: 8] = 8'hFF;          vt[5] = '{2'd2, l, 8'h00};
    l = '0; l[87:80] = 8'h3C; l[167:160] = 8'h0F;              vt[6] = '{2'd0, l, 8'h33};

    do_reset();
    check("rst_valid", 32'(resp_valido), 0);
    check("rst_hash", 32'(resp_hash), 0);
    check("rst_id", 32'(resp_id), 0);
    check("rst_pronto", 32'(req_pronto), 0);
    check("rst_state", 32'(estado_dbg), 0);

    for (int i = 0; i < 7; i++) run_single(vt[i]);

    // round-robin with all requesters valid, one grant every 3 cycles
    do_reset();
    for (int i = 0; i < N; i++) req_linha[i*512 +: 8] = 8'(i + 1);
    req_valido = '1;
    #1;
    for (int g = 0; g < 5; g++) begin
      check("rr_grant", 32'(req_pronto), 32'(N'(1) << rr_exp(g)));
      tick();
      check("rr_busy_pronto", 32'(req_pronto), 0);
      tick();
      check("rr_resp_valid", 32'(resp_valido), 1);
      check("rr_resp_id", 32'(resp_id), 32'(rr_exp(g)));
      check("rr_resp_hash", 32'(resp_hash), 32'(rr_exp(g) + 8'd1));
      check("rr_resp_pronto", 32'(req_pronto), 0);
      tick();
    end

    // back-pressure: response held for 10 cycles
    do_reset();
    for (int i = 0; i < N; i++) req_linha[i*512 +: 8] = 8'(8'h10 + i);
    req_valido = '1;
    resp_pronto = 1'b0;
    #1;
    check("bp_grant", 32'(req_pronto), 32'h1);
    tick();
    tick();
    h0 = 8'h10;
    id0 = 2'd0;
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", 32'(resp_valido), 1);
      check("bp_hash", 32'(resp_hash), 32'(h0));
      check("bp_id", 32'(resp_id), 32'(id0));
      check("bp_pronto", 32'(req_pronto), 0);
      check("bp_state", 32'(estado_dbg), 2);
      tick();
    end
    resp_pronto = 1'b1;
    tick();
    check("bp_release_valid", 32'(resp_valido), 0);
`ifdef ARB_PRIORIDADE_FIXA_EN
    check("bp_next_grant", 32'(req_pronto), 32'h1);
`else
    check("bp_next_grant", 32'(req_pronto), 32'h2);
`endif

    // reset while in HASH
    do_reset();
    req_linha = '0;
    for (int i = 0; i < N; i++) req_linha[i*512 +: 8] = 8'(8'h20 + i);
    req_valido = 4'b0010;
    #1;
    check("rh_grant", 32'(req_pronto), 32'h2);
    tick();
    req_valido = '0;
    check("rh_state_hash", 32'(estado_dbg), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rh_valid", 32'(resp_valido), 0);
    check("rh_state", 32'(estado_dbg), 0);
    tick();
    check("rh_no_resp", 32'(resp_valido), 0);
    req_valido = 4'b0110;
    #1;
    check("rh_ptr0_grant", 32'(req_pronto), 32'h2);
    tick();
    req_valido = '0;
    tick();
    check("rh_new_resp_id", 32'(resp_id), 1);
    check("rh_new_resp_hash", 32'(resp_hash), 32'h21);
    tick();

    // reset while in RESP
    resp_pronto = 1'b0;
    req_valido = 4'b0100;
    #1;
    check("rr2_grant", 32'(req_pronto), 32'h4);
    tick();
    req_valido = '0;
    tick();
    check("rr2_resp_valid", 32'(resp_valido), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    resp_pronto = 1'b1;
    check("rr2_valid", 32'(resp_valido), 0);
    check("rr2_hash", 32'(resp_hash), 0);
    check("rr2_state", 32'(estado_dbg), 0);
    tick();
    check("rr2_no_resp", 32'(resp_valido), 0);
    req_valido = 4'b1100;
    #1;
    check("rr2_ptr0_grant", 32'(req_pronto), 32'h4);
    tick();
    req_valido = '0;
    tick();
    tick();

    // withdrawn request while busy
    do_reset();
    resp_pronto = 1'b0;
    req_valido = 4'b0001;
    #1;
    check("wd_grant0", 32'(req_pronto), 32'h1);
    tick();
    req_valido = 4'b0100;
    tick();
    for (int c = 0; c < 3; c++) begin
      check("wd_busy_pronto", 32'(req_pronto), 0);
      tick();
    end
    req_valido = '0;
    resp_pronto = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      check("wd_idle_pronto", 32'(req_pronto), 0);
      check("wd_idle_valid", 32'(resp_valido), 0);
      check("wd_idle_state", 32'(estado_dbg), 0);
      tick();
    end
    req_valido = '1;
    #1;
`ifdef ARB_PRIORIDADE_FIXA_EN
    check("wd_ptr_kept", 32'(req_pronto), 32'h1);
`else
    check("wd_ptr_kept", 32'(req_pronto), 32'h2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
